ssd_display_scheduler: RTL and testbench



---
 rtl/ssd_pkg.sv | 20 ++
 rtl/ssd_rr_pick.sv | 28 ++
 rtl/ssd_display_scheduler.sv | 139 +++++++++++++
 tb/tb_ssd_display_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and state encoding for the seven-segment display scheduler.
// Pure definitions: no logic, no latency, no flow control.
package ssd_pkg;

  localparam int DEF_NUM_SRC      = 4;
  localparam int DEF_DWELL_CYCLES = 125000000;

  localparam logic [7:0] NONE_CODE = 8'h80;

  // Signed range ssd_driver can render on two digits
  localparam int DISP_MIN = -9;
  localparam int DISP_MAX = 99;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_URGENT = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_rr_pick.sv
// Circular first-set finder: lowest set req bit at or after start, wrapping.
// Purely combinational, zero latency; no flow control.
module ssd_rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = start;
    for (int k = 0; k < N; k++) begin
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = (pos == IW'(N - 1)) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_display_scheduler.sv
// Time-shares one 2-digit display among NUM_SRC sources: round-robin dwell, urgent preempt, hold.
// Outputs registered; ssd_value lags sel_id by one cycle. No backpressure: sources are sampled live.
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int          NUM_SRC      = DEF_NUM_SRC,
  parameter int          DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter logic [7:0]  NONE_CODE    = ssd_pkg::NONE_CODE,
  localparam int SW = $clog2(NUM_SRC),
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC-1:0]     src_urgent,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic                   hold,
  output logic [7:0]             ssd_value,
  output logic [SW-1:0]          sel_id,
  output logic                   disp_valid,
  output logic [NUM_SRC-1:0]     src_ack
);

  state_t             state, state_nxt;
  logic [SW-1:0]      sel_nxt;
  logic [SW-1:0]      rr_ptr, rr_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NUM_SRC-1:0] ack_nxt;

  logic [NUM_SRC-1:0] urg_req;
  logic [SW-1:0]      sel_inc;
  logic [SW-1:0]      rr_start;
  logic               rr_found, urg_found;
  logic [SW-1:0]      rr_idx, urg_idx;
  logic               last_cnt;

  assign urg_req  = src_urgent & src_valid;
  assign sel_inc  = (sel_id == SW'(NUM_SRC - 1)) ? '0 : sel_id + 1'b1;
  // While showing, search strictly after the current source so it comes up last
  assign rr_start = (state == ST_SHOW) ? sel_inc : rr_ptr;
  assign last_cnt = (cnt == CW'(DWELL_CYCLES - 1));

  ssd_rr_pick #(.N(NUM_SRC)) u_rr_pick (
    .req   (src_valid),
    .start (rr_start),
    .found (rr_found),
    .idx   (rr_idx)
  );

  ssd_rr_pick #(.N(NUM_SRC)) u_urg_pick (
    .req   (urg_req),
    .start ('0),
    .found (urg_found),
    .idx   (urg_idx)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_id;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    ack_nxt   = '0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (urg_found) begin
          state_nxt = ST_URGENT;
          sel_nxt   = urg_idx;
        end else if (rr_found) begin
          state_nxt = ST_SHOW;
          sel_nxt   = rr_idx;
        end
      end
      ST_SHOW: begin
        rr_nxt = sel_inc;
        if (urg_found) begin
          state_nxt = ST_URGENT;
          sel_nxt   = urg_idx;
          cnt_nxt   = '0;
        end else if (!src_valid[sel_id]) begin
          cnt_nxt = '0;
          if (rr_found) sel_nxt = rr_idx;
          else state_nxt = ST_IDLE;
        end else if (last_cnt) begin
          ack_nxt[sel_id] = 1'b1;
          cnt_nxt         = '0;
          if (!hold) sel_nxt = rr_idx;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_URGENT: begin
        // Lowest urgent index differing from sel means a lower one arrived or sel dropped
        if (urg_found && (urg_idx != sel_id)) begin
          sel_nxt = urg_idx;
          cnt_nxt = '0;
        end else if (!urg_found) begin
          cnt_nxt = '0;
          if (rr_found) begin
            state_nxt = ST_SHOW;
            sel_nxt   = rr_idx;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (last_cnt) begin
          ack_nxt[sel_id] = 1'b1;
          cnt_nxt         = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel_id     <= '0;
      cnt        <= '0;
      rr_ptr     <= '0;
      src_ack    <= '0;
      ssd_value  <= NONE_CODE;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel_id     <= sel_nxt;
      cnt        <= cnt_nxt;
      rr_ptr     <= rr_nxt;
      src_ack    <= ack_nxt;
      disp_valid <= (state != ST_IDLE);
      ssd_value  <= (state != ST_IDLE) ? src_data[{sel_id, 3'b000} +: 8] : NONE_CODE;
    end
  end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed bench for ssd_display_scheduler with NUM_SRC=4, DWELL_CYCLES=8.
module tb_ssd_display_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  src_valid;
  logic [3:0]  src_urgent;
  logic [31:0] src_data;
  logic        hold;
  logic [7:0]  ssd_value;
  logic [1:0]  sel_id;
  logic        disp_valid;
  logic [3:0]  src_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] s1_vals [4] = '{8'd3, 8'd17, 8'hFB, 8'd99};

  always #5 clk = ~clk;

  ssd_display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_valid  (src_valid),
    .src_urgent (src_urgent),
    .src_data   (src_data),
    .hold       (hold),
    .ssd_value  (ssd_value),
    .sel_id     (sel_id),
    .disp_valid (disp_valid),
    .src_ack    (src_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    src_valid  = '0;
    src_urgent = '0;
    src_data   = '0;
    hold       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state and single source
    do_reset();
    check("rst_value", ssd_value, 8'h80);
    check("rst_sel", sel_id, 0);
    check("rst_disp", disp_valid, 0);
    check("rst_ack", src_ack, 0);
    repeat (3) tick();
    check("idle_value", ssd_value, 8'h80);
    check("idle_disp", disp_valid, 0);
    check("idle_ack", src_ack, 0);
    src_valid = 4'b0100;
    src_data  = {8'd0, 8'd42, 8'd0, 8'd0};
    tick();
    check("s2_sel", sel_id, 2);
    check("s2_value_lag", ssd_value, 8'h80);
    tick();
    check("s2_value", ssd_value, 8'h2A);
    check("s2_disp", disp_valid, 1);
    repeat (6) tick();
    check("s2_noack7", src_ack, 0);
    tick();
    check("s2_ack8", src_ack, 4'b0100);
    check("s2_sel8", sel_id, 2);
    repeat (7) tick();
    check("s2_noack15", src_ack, 0);
    tick();
    check("s2_ack16", src_ack, 4'b0100);

    // Full round-robin over four sources
    do_reset();
    src_valid = 4'b1111;
    src_data  = {8'd99, 8'hFB, 8'd17, 8'd3};
    tick();
    check("s1_sel_first", sel_id, 0);
    check("s1_disp_lag", disp_valid, 0);
    for (int s = 0; s < 4; s++) begin
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k == 1) check("s1_value", ssd_value, s1_vals[s]);
        if (k == 1) check("s1_disp", disp_valid, 1);
        if (k == 7) check("s1_noack", src_ack, 0);
        if (k == 8) check("s1_ack", src_ack, 32'(1) << s);
        if (k == 8) check("s1_next_sel", sel_id, (s + 1) % 4);
      end
    end

    // Urgent preempt mid-dwell, then hold, then urgent through hold
    do_reset();
    src_valid = 4'b1111;
    src_data  = {8'd7, 8'hFB, 8'd17, 8'd3};
    repeat (4) tick();
    check("s3_pre_sel", sel_id, 0);
    src_urgent = 4'b1000;
    tick();
    check("s3_urg_sel", sel_id, 3);
    check("s3_no_ack0", src_ack, 0);
    tick();
    check("s3_urg_value", ssd_value, 8'd7);
    repeat (6) tick();
    check("s3_noack7", src_ack, 0);
    tick();
    check("s3_ack3", src_ack, 4'b1000);
    check("s3_keep_sel", sel_id, 3);
    src_urgent = 4'b0000;
    tick();
    check("s3_resume_sel", sel_id, 1);
    check("s3_resume_noack", src_ack, 0);
    hold = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k % 8 == 0) check("s4_hold_ack", src_ack, 4'b0010);
      if (k == 12) check("s4_hold_noack", src_ack, 0);
      if (k % 6 == 0) check("s4_hold_sel", sel_id, 1);
    end
    src_urgent = 4'b0001;
    tick();
    check("s4_urg_hold_sel", sel_id, 0);
    check("s4_urg_hold_ack", src_ack, 0);
    src_urgent = 4'b0000;
    hold = 1'b0;

    // Urgent coincides with dwell expiry
    do_reset();
    src_valid = 4'b1111;
    src_data  = {8'd99, 8'hFB, 8'd17, 8'd3};
    repeat (8) tick();
    check("s6_pre_sel", sel_id, 0);
    src_urgent = 4'b0010;
    tick();
    check("s6_sel", sel_id, 1);
    check("s6_no_ack0", src_ack, 0);
    src_urgent = 4'b0000;
    tick();
    check("s6_resume_sel", sel_id, 1);

    // Valid drop mid-dwell, then async reset mid-dwell
    do_reset();
    src_valid = 4'b1100;
    src_data  = {8'd55, 8'd42, 8'd17, 8'd3};
    tick();
    check("s5_sel2", sel_id, 2);
    repeat (5) tick();
    src_valid = 4'b1000;
    tick();
    check("s5_drop_sel", sel_id, 3);
    check("s5_drop_noack", src_ack, 0);
    repeat (2) tick();
    check("s5_value", ssd_value, 8'd55);
    check("s5_disp", disp_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("s5_rst_value", ssd_value, 8'h80);
    check("s5_rst_sel", sel_id, 0);
    check("s5_rst_disp", disp_valid, 0);
    check("s5_rst_ack", src_ack, 0);
    src_valid = 4'b1111;
    tick();
    reset_n = 1'b1;
    tick();
    check("s5_rearb_sel", sel_id, 0);
    check("s5_rearb_value", ssd_value, 8'h80);
    tick();
    check("s5_rearb_show", ssd_value, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
